// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit device.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Values of address[2] selecting each register.
  localparam logic DATA_OFFSET   = 1'b0;
  localparam logic STATUS_OFFSET = 1'b1;

  // STATUS register bit positions.
  localparam int FULL_BIT  = 0;
  localparam int EMPTY_BIT = 1;
  localparam int BUSY_BIT  = 2;

endpackage

// File: rtl/uart_tx_device_sync_fifo.sv
// sync_fifo: first-word-fall-through synchronous FIFO, reusable by TX and RX.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  // Advance read/write pointers; they wrap modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Write the storage array on push.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_device.sv
// uart_tx_device: memory-mapped 8N1 UART transmitter with a TX FIFO and
// STATUS register. Define UART_TX_IRQ_EN to build the registered irq output
// (fifo empty and transmitter idle); otherwise irq is tied low.
module uart_tx_device
  import uart_pkg::*;
#(
  parameter int DIVIDER    = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  output logic        ready,
  input  logic [31:0] address,
  input  logic [3:0]  wstrobe,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        tx
);

  tx_state_t   state_q, state_d;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        baud_done;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_rdata;

  logic        is_status, is_read, is_push, accept;
  logic [31:0] status_word;
  logic        unused_bits;

  assign unused_bits = ^{address[31:3], address[1:0], wdata[31:8]};

  assign is_status = (address[2] == STATUS_OFFSET);
  assign is_read   = (wstrobe == 4'b0000);
  assign is_push   = (address[2] == DATA_OFFSET) && wstrobe[0];
  // A DATA push waits while the FIFO is full; everything else is taken at once.
  assign accept    = valid && !ready && !(is_push && fifo_full);
  assign fifo_push = accept && is_push;
  assign baud_done = (baud_q == 16'(DIVIDER - 1));

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .wdata(wdata[7:0]),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Assemble the STATUS register value.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    status_word            = '0;
    status_word[FULL_BIT]  = fifo_full;
    status_word[EMPTY_BIT] = fifo_empty;
    status_word[BUSY_BIT]  = (state_q != IDLE);
  end

  // Bus response: one-cycle ready pulse with read data captured at acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= accept;
      rdata <= (accept && is_status && is_read) ? status_word : '0;
    end
  end

  // Frame sequencing: next state and FIFO pop.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = START;
        end
      end
      START: if (baud_done) state_d = DATA;
      DATA:  if (baud_done && bit_q == 3'd7) state_d = STOP;
      STOP: begin
        if (baud_done) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Baud counter, bit index and shift register; a pop always starts a new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else if (fifo_pop) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= fifo_rdata;
    end else if (state_q == IDLE) begin
      baud_q <= '0;
    end else begin
      baud_q <= baud_done ? 16'd0 : baud_q + 16'd1;
      if (state_q == DATA && baud_done) begin
        bit_q   <= bit_q + 3'd1;
        shift_q <= {1'b0, shift_q[7:1]};
      end
    end
  end

  // Registered serial line driven from the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx <= 1'b1;
    end else begin
      case (state_q)
        START:   tx <= 1'b0;
        DATA:    tx <= shift_q[0];
        default: tx <= 1'b1;
      endcase
    end
  end

`ifdef UART_TX_IRQ_EN
  // Interrupt when all queued bytes have been sent and the line is idle.
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= fifo_empty && (state_q == IDLE);
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_device.sv
// Testbench for uart_tx_device (DIVIDER=4, FIFO_DEPTH=4). A line monitor
// decodes frames from tx and a byte queue holds what the bus wrote.
module tb_uart_tx_device;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_IRQ_EN
  localparam logic IRQ_BUILD = 1'b1;
`else
  localparam logic IRQ_BUILD = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        valid;
  logic        ready;
  logic [31:0] address;
  logic [3:0]  wstrobe;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic        tx;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int fall_cnt = 0;
  logic prev_tx = 1'b1;

  logic [7:0] rx_q[$];
  int         start_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  ws;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  uart_tx_device #(
    .DIVIDER(DIV),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .valid(valid),
    .ready(ready),
    .address(address),
    .wstrobe(wstrobe),
    .wdata(wdata),
    .rdata(rdata),
    .irq(irq),
    .tx(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (prev_tx === 1'b1 && tx === 1'b0) fall_cnt <= fall_cnt + 1;
    prev_tx <= tx;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // UART line decoder: sample each bit one and a half cycles after it starts.
  initial begin : line_monitor
    logic [7:0] b;
    int t0;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
        t0 = cyc;
        @(negedge clk);
        check("mon_start_bit", {31'b0, tx}, 32'h0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        check("mon_stop_bit", {31'b0, tx}, 32'h1);
        rx_q.push_back(b);
        start_q.push_back(t0);
      end
    end
  end

  task automatic at_cycle(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus(input logic [31:0] addr, input logic [3:0] ws, input logic [31:0] wd,
                     output logic [31:0] rd, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    valid   = 1'b1;
    address = addr;
    wstrobe = ws;
    wdata   = wd;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (ready !== 1'b1 && n < 3000);
    if (ready !== 1'b1) check("bus_timeout", {31'b0, ready}, 32'h1);
    rd      = rdata;
    acc     = cyc;
    valid   = 1'b0;
    wstrobe = 4'h0;
  endtask

  task automatic wr(input logic [7:0] b, output int acc);
    logic [31:0] rd;
    bus(32'h10, 4'h1, {24'h0, b}, rd, acc);
    exp_q.push_back(b);
  endtask

  task automatic wait_rx(input int n);
    int k;
    k = 0;
    while (rx_q.size() < n && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("rx_count", 32'(rx_q.size()), 32'(n));
  endtask

  task automatic scoreboard(input string tag);
    wait_rx(exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
    start_q.delete();
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic [31:0] rd;
    int a1, acc, f0;
    logic [7:0] b;
    logic [3:0] ws;
    logic [31:0] addr;
    logic [7:0] pat;

    // Reset
    reset = 1'b1; valid = 1'b0; address = '0; wstrobe = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", {31'b0, tx}, 32'h1);
    check("reset_ready", {31'b0, ready}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Register map vectors with an idle transmitter and empty FIFO.
    vecs[0] = '{32'h14, 4'h0, 32'h0,         1'b1, 32'h2};
    vecs[1] = '{32'h10, 4'h0, 32'h0,         1'b1, 32'h0};
    vecs[2] = '{32'h14, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[3] = '{32'h1C, 4'h0, 32'h0,         1'b1, 32'h2};
    vecs[4] = '{32'h10, 4'hE, 32'h77,        1'b0, 32'h0};
    vecs[5] = '{32'h14, 4'h0, 32'h0,         1'b1, 32'h2};
    for (int i = 0; i < 6; i++) begin
      bus(vecs[i].addr, vecs[i].ws, vecs[i].wd, rd, acc);
      if (vecs[i].chk) check($sformatf("regmap_vec%0d", i), rd, vecs[i].exp);
    end
    repeat (20) @(posedge clk);
    #1;
    check("discard_no_tx", 32'(fall_cnt), 32'h0);

    // Single byte 0x55: exact frame timing.
    bus(32'h10, 4'h1, 32'h55, rd, a1);
    exp_q.push_back(8'h55);
    check("single_irq_hold", {31'b0, irq}, {31'b0, IRQ_BUILD});
    at_cycle(a1 + 1);
    check("single_tx_idle", {31'b0, tx}, 32'h1);
    check("single_ready_pulse", {31'b0, ready}, 32'h0);
    check("single_irq_clear", {31'b0, irq}, 32'h0);
    at_cycle(a1 + 2);
    check("single_start", {31'b0, tx}, 32'h0);
    at_cycle(a1 + 5);
    check("single_start_end", {31'b0, tx}, 32'h0);
    pat = 8'h55;
    for (int j = 1; j <= 9; j++) begin
      at_cycle(a1 + 2 + DIV * j);
      check($sformatf("single_bit%0d", j), {31'b0, tx}, (j == 9) ? 32'h1 : {31'b0, pat[j-1]});
    end
    at_cycle(a1 + 41);
    check("single_irq_before_end", {31'b0, irq}, 32'h0);
    at_cycle(a1 + 42);
    check("single_irq_after_end", {31'b0, irq}, {31'b0, IRQ_BUILD});
    check("single_line_idle", {31'b0, tx}, 32'h1);
    scoreboard("single");

    // Back-to-back "ABC": contiguous frames, busy throughout.
    wr(8'h41, a1);
    wr(8'h42, acc);
    wr(8'h43, acc);
    while (cyc < a1 + 110) begin
      bus(32'h14, 4'h0, 32'h0, rd, acc);
      check("b2b_busy", {31'b0, rd[2]}, 32'h1);
    end
    wait_rx(3);
    if (start_q.size() >= 3) begin
      check("b2b_gap1", 32'(start_q[1] - start_q[0]), 32'(10 * DIV));
      check("b2b_gap2", 32'(start_q[2] - start_q[1]), 32'(10 * DIV));
    end
    scoreboard("b2b");

    // Full stall: sixth push waits for the second pop.
    wr(8'hA1, a1);
    for (int i = 0; i < 4; i++) wr(8'hB0 + 8'(i), acc);
    bus(32'h14, 4'h0, 32'h0, rd, acc);
    check("stall_status_full", rd, 32'h5);
    wr(8'hC6, acc);
    check("stall_accept_cycle", 32'(acc - a1), 32'd42);
    scoreboard("stall");

    // Reset during byte 2 of 3.
    wr(8'h11, a1);
    wr(8'h22, acc);
    wr(8'h33, acc);
    at_cycle(a1 + 55);
    reset = 1'b1; valid = 1'b1; address = 32'h14; wstrobe = 4'h0;
    @(posedge clk);
    #1;
    check("midrst_tx", {31'b0, tx}, 32'h1);
    check("midrst_drop", {31'b0, ready}, 32'h0);
    valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    f0 = fall_cnt;
    bus(32'h14, 4'h0, 32'h0, rd, acc);
    check("midrst_status", rd, 32'h2);
    repeat (200) @(posedge clk);
    #1;
    check("midrst_no_tx", 32'(fall_cnt), 32'(f0));
    rx_q.delete();
    exp_q.delete();
    start_q.delete();

    // Randomized traffic against the byte queue model.
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 50)) @(posedge clk);
      b    = 8'($urandom);
      ws   = 4'($urandom_range(1, 15));
      addr = ($urandom_range(0, 1) == 0) ? 32'h10 : 32'h18;
      bus(addr, ws, {24'h0, b}, rd, acc);
      if (ws[0]) exp_q.push_back(b);
    end
    scoreboard("rand");
    bus(32'h14, 4'h0, 32'h0, rd, acc);
    check("final_status", rd, 32'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
